// File: rtl/ysyx_23060096_regfile_mp.sv
// Multi-port register file with pending scoreboard and sequential clear engine.
// Optional macro RF_BYPASS_EN forwards same-cycle writes to the read ports.
module ysyx_23060096_regfile_mp #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_RD     = 2,
  parameter int NUM_WR     = 2,
  parameter int ZERO_REG   = 1
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic [NUM_WR-1:0]            wen,
  input  logic [NUM_WR*ADDR_WIDTH-1:0] waddr,
  input  logic [NUM_WR*DATA_WIDTH-1:0] wdata,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] raddr,
  output logic [NUM_RD*DATA_WIDTH-1:0] rdata,
  output logic [NUM_RD-1:0]            rbusy,
  input  logic                         iss_vld,
  input  logic [ADDR_WIDTH-1:0]        iss_rd,
  input  logic                         clr_req,
  output logic                         clr_busy
);

  localparam int AW    = ADDR_WIDTH;
  localparam int DW    = DATA_WIDTH;
  localparam int DEPTH = 1 << AW;

  typedef enum logic {
    IDLE,
    CLEAR
  } state_t;

  state_t          state;
  logic [AW-1:0]   cnt;
  logic [DW-1:0]   mem [DEPTH];
  logic [DEPTH-1:0] pend;

  function automatic logic usable(input logic [AW-1:0] a);
    return !((ZERO_REG != 0) && (a == '0));
  endfunction

  // Later ports are assigned last, so the highest port index wins.
  // Issue is applied after writes so a new producer keeps the entry pending.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      cnt   <= '0;
      pend  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          for (int p = 0; p < NUM_WR; p++) begin
            if (wen[p] && usable(waddr[p*AW +: AW])) begin
              mem[waddr[p*AW +: AW]]  <= wdata[p*DW +: DW];
              pend[waddr[p*AW +: AW]] <= 1'b0;
            end
          end
          if (iss_vld && usable(iss_rd)) pend[iss_rd] <= 1'b1;
          if (clr_req) begin
            state <= CLEAR;
            cnt   <= '0;
          end
        end
        CLEAR: begin
          mem[cnt]  <= '0;
          pend[cnt] <= 1'b0;
          cnt       <= cnt + 1'b1;
          if (cnt == '1) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign clr_busy = (state == CLEAR);

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [AW-1:0] ra;
    logic          live;
    logic [DW-1:0] rd_val;
    logic          rd_bsy;

    assign ra   = raddr[i*AW +: AW];
    assign live = rstn && usable(ra);

    always_comb begin
      rd_val = live ? mem[ra] : '0;
      rd_bsy = live && pend[ra];
`ifdef RF_BYPASS_EN
      for (int p = 0; p < NUM_WR; p++) begin
        if (live && (state == IDLE) && wen[p] &&
            (waddr[p*AW +: AW] == ra)) begin
          rd_val = wdata[p*DW +: DW];
          rd_bsy = 1'b0;
        end
      end
`endif
    end

    assign rdata[i*DW +: DW] = rd_val;
    assign rbusy[i]          = rd_bsy;
  end

endmodule

// File: tb/tb_ysyx_23060096_regfile_mp.sv
// Randomized bench for ysyx_23060096_regfile_mp against an array-based model.
// Honors RF_BYPASS_EN the same way the design does.
module tb_ysyx_23060096_regfile_mp;

  logic        clk = 1'b0;
  logic        rstn;
  logic [1:0]  wen;
  logic [9:0]  waddr;
  logic [63:0] wdata;
  logic [9:0]  raddr;
  logic [63:0] rdata;
  logic [1:0]  rbusy;
  logic        iss_vld;
  logic [4:0]  iss_rd;
  logic        clr_req;
  logic        clr_busy;

  ysyx_23060096_regfile_mp dut (
    .clk      (clk),
    .rstn     (rstn),
    .wen      (wen),
    .waddr    (waddr),
    .wdata    (wdata),
    .raddr    (raddr),
    .rdata    (rdata),
    .rbusy    (rbusy),
    .iss_vld  (iss_vld),
    .iss_rd   (iss_rd),
    .clr_req  (clr_req),
    .clr_busy (clr_busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] ref_mem [32];
  bit          ref_pend [32];
  int          clr_left;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      ref_mem[i]  = '0;
      ref_pend[i] = 1'b0;
    end
    clr_left = 0;
  endtask

  function automatic void exp_read(input logic [4:0] a,
                                   output logic [31:0] d, output logic b);
    d = (a == 0) ? 32'h0 : ref_mem[a];
    b = (a != 0) && ref_pend[a];
`ifdef RF_BYPASS_EN
    if (clr_left == 0 && a != 0)
      for (int p = 0; p < 2; p++)
        if (wen[p] && waddr[p*5 +: 5] == a) begin
          d = wdata[p*32 +: 32];
          b = 1'b0;
        end
`endif
  endfunction

  task automatic model_commit();
    if (clr_left > 0) begin
      ref_mem[32 - clr_left]  = '0;
      ref_pend[32 - clr_left] = 1'b0;
      clr_left--;
    end else begin
      for (int p = 0; p < 2; p++)
        if (wen[p] && waddr[p*5 +: 5] != 0) begin
          ref_mem[waddr[p*5 +: 5]]  = wdata[p*32 +: 32];
          ref_pend[waddr[p*5 +: 5]] = 1'b0;
        end
      if (iss_vld && iss_rd != 0) ref_pend[iss_rd] = 1'b1;
      if (clr_req) clr_left = 32;
    end
  endtask

  task automatic check_outputs();
    logic [31:0] d;
    logic        b;
    for (int i = 0; i < 2; i++) begin
      exp_read(raddr[i*5 +: 5], d, b);
      check("rdata", rdata[i*32 +: 32], d);
      check("rbusy", 32'(rbusy[i]), 32'(b));
    end
    check("clr_busy", 32'(clr_busy), 32'(clr_left > 0));
  endtask

  task automatic tick();
    #2;
    check_outputs();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic idle();
    wen     = '0;
    waddr   = '0;
    wdata   = '0;
    iss_vld = 1'b0;
    iss_rd  = '0;
    clr_req = 1'b0;
  endtask

  task automatic rand_inputs(input bit allow_clr);
    logic [4:0] a0, a1;
    a0 = ($urandom % 4 == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
    a1 = ($urandom % 4 == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
    wen     = 2'($urandom);
    waddr   = {a1, a0};
    wdata   = {$urandom, $urandom};
    raddr   = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
    iss_vld = 1'($urandom);
    iss_rd  = 5'($urandom_range(0, 7));
    clr_req = allow_clr && ($urandom % 60 == 0);
  endtask

  task automatic async_reset();
    rstn = 1'b0;
    #1;
    check("rst_rd0", rdata[31:0], 32'h0);
    check("rst_rd1", rdata[63:32], 32'h0);
    check("rst_busy", 32'(rbusy), 32'h0);
    check("rst_clr", 32'(clr_busy), 32'h0);
    model_reset();
    idle();
    @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  initial begin
    int n;
    idle();
    raddr = '0;
    rstn  = 1'b0;
    model_reset();
    #12;
    check("init_clr", 32'(clr_busy), 32'h0);
    check("init_rd", rdata[31:0], 32'h0);
    @(posedge clk);
    #1;
    rstn = 1'b1;

    // single write then read next cycle
    wen = 2'b01; waddr = {5'd0, 5'd3}; wdata = {32'h0, 32'hDEADBEEF};
    raddr = {5'd9, 5'd3};
    tick();
    idle();
    #1;
    check("t2_rd", rdata[31:0], 32'hDEADBEEF);
    tick();

    // two ports, same address: port 1 wins
    wen = 2'b11; waddr = {5'd5, 5'd5}; wdata = {32'h22, 32'h11};
    tick();
    idle();
    raddr = {5'd0, 5'd5};
    #1;
    check("t3_rd", rdata[31:0], 32'h22);
    tick();

    // index 0 is hardwired
    wen = 2'b01; waddr = {5'd0, 5'd0}; wdata = {32'h0, 32'h55};
    iss_vld = 1'b1; iss_rd = 5'd0;
    raddr = {5'd0, 5'd0};
    tick();
    idle();
    #1;
    check("t4_rd", rdata[31:0], 32'h0);
    check("t4_busy", 32'(rbusy[0]), 32'h0);
    tick();

    // pending set, cleared by write, kept by issue+write
    iss_vld = 1'b1; iss_rd = 5'd7; raddr = {5'd0, 5'd7};
    tick();
    idle();
    #1;
    check("t5_set", 32'(rbusy[0]), 32'h1);
    wen = 2'b01; waddr = {5'd0, 5'd7}; wdata = {32'h0, 32'h77};
    tick();
    idle();
    #1;
    check("t5_clr", 32'(rbusy[0]), 32'h0);
    check("t5_val", rdata[31:0], 32'h77);
    iss_vld = 1'b1; iss_rd = 5'd7;
    wen = 2'b01; waddr = {5'd0, 5'd7}; wdata = {32'h0, 32'h78};
    tick();
    idle();
    #1;
    check("t5_both", 32'(rbusy[0]), 32'h1);
    tick();

    // same-cycle read of a register being written
    wen = 2'b01; waddr = {5'd0, 5'd9}; wdata = {32'h0, 32'h1};
    tick();
    wen = 2'b01; waddr = {5'd0, 5'd9}; wdata = {32'h0, 32'hA5};
    raddr = {5'd9, 5'd0};
    #1;
`ifdef RF_BYPASS_EN
    check("t7_byp", rdata[63:32], 32'hA5);
`else
    check("t7_old", rdata[63:32], 32'h1);
`endif
    tick();
    idle();

    // fill, then full clear with traffic that must be dropped
    for (int a = 0; a < 32; a += 2) begin
      wen = 2'b11; waddr = {5'(a + 1), 5'(a)}; wdata = {$urandom, $urandom};
      iss_vld = 1'b1; iss_rd = 5'(a + 1);
      tick();
    end
    idle();
    wen = 2'b11; waddr = {5'd12, 5'd11}; wdata = {32'h12, 32'h11};
    clr_req = 1'b1;
    tick();
    n = 0;
    while (clr_busy && n < 100) begin
      rand_inputs(1'b0);
      clr_req = 1'b1;
      tick();
      n++;
    end
    check("t6_len", 32'(n), 32'd32);
    idle();
    for (int a = 0; a < 32; a++) begin
      raddr = {5'(a), 5'(a)};
      #1;
      check("t6_zero", rdata[31:0], 32'h0);
      check("t6_nbsy", 32'(rbusy[0]), 32'h0);
      tick();
    end

    // reset in the middle of a clear
    clr_req = 1'b1;
    tick();
    idle();
    repeat (5) tick();
    rand_inputs(1'b0);
    async_reset();
    tick();

    // randomized traffic
    for (int c = 0; c < 1500; c++) begin
      rand_inputs(1'b1);
      if ($urandom % 300 == 0) async_reset();
      else tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

endmodule
